// File: rtl/daisy_pkg.sv
// Daisy-chain receiver shared definitions.
package daisy_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_HUNT,
    ST_SETTLE,
    ST_CHECK,
    ST_LOCKED,
    ST_FAIL
  } daisy_state_e;

  localparam logic [15:0] DAISY_TRAIN_PAT   = 16'h00FF;
  localparam int unsigned DAISY_SYNC_STAGES = 2;

endpackage

// File: rtl/red_pitaya_daisy_rx_gearbox.sv
// Slice-to-word gearbox with a slice-slip input that delays the word boundary by one slice.
module red_pitaya_daisy_rx_gearbox #(
  parameter int unsigned DW = 4,
  parameter int unsigned NS = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [DW-1:0]    slc_dat_i,
  input  logic             slip_i,
  output logic [DW*NS-1:0] word_o,
  output logic             wv_o
);

  localparam int unsigned WW = DW*NS;
  localparam int unsigned HW = DW*(NS-1);
  localparam int unsigned PW = (NS > 1) ? $clog2(NS) : 1;

  logic [HW-1:0] r_hist;
  logic [PW-1:0] r_ph;
  logic [WW-1:0] r_word;
  logic          r_wv;
  logic [WW-1:0] w_cat;
  logic          w_last;

  always_comb begin
    w_cat  = {slc_dat_i, r_hist};
    w_last = (r_ph == PW'(NS-1));
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_hist <= '0;
      r_ph   <= '0;
      r_word <= '0;
      r_wv   <= 1'b0;
    end else begin
      r_hist <= w_cat[WW-1:DW];
      r_wv   <= w_last;
      if (w_last) begin
        r_word <= w_cat;
      end
      if (!slip_i) begin
        r_ph <= w_last ? '0 : r_ph + PW'(1);
      end
    end
  end

  assign word_o = r_word;
  assign wv_o   = r_wv;

endmodule

// File: rtl/red_pitaya_daisy_rx_align.sv
// Daisy-chain receiver word alignment and link training.
module red_pitaya_daisy_rx_align
  import daisy_pkg::*;
#(
  parameter int unsigned          DW        = 4,
  parameter int unsigned          NS        = 4,
  parameter logic [DW*NS-1:0]     TRAIN_PAT = (DW*NS)'(DAISY_TRAIN_PAT),
  parameter int unsigned          SETTLE    = 8,
  parameter int unsigned          LOCK_N    = 4,
  parameter int unsigned          UNLOCK_N  = 4,
  parameter int unsigned          MAX_TRY   = 2*DW*NS
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             cfg_en_i,
  input  logic             cfg_train_i,
  input  logic [DW-1:0]    slc_dat_i,
  output logic             bitslip_o,
  output logic             par_dv_o,
  output logic [DW*NS-1:0] par_dat_o,
  output logic             sts_locked_o,
  output logic             sts_fail_o,
  output logic [15:0]      sts_err_cnt_o,
  output logic [7:0]       sts_slip_cnt_o
);

  localparam int unsigned WW = DW*NS;
  localparam int unsigned TW = $clog2(MAX_TRY+1);
  localparam int unsigned GW = $clog2(LOCK_N+1);
  localparam int unsigned BW = $clog2(UNLOCK_N+1);
  localparam int unsigned SW = (DW > 1) ? $clog2(DW) : 1;
  localparam int unsigned YS = DAISY_SYNC_STAGES;

  logic [YS-1:0] r_en_sync;
  logic [YS-1:0] r_train_sync;
  logic          w_en;
  logic          w_train;

  daisy_state_e  r_state;
  logic          r_bitslip;
  logic          r_sslip;
  logic          r_locked;
  logic          r_fail;
  logic [TW-1:0] r_try;
  logic [SW-1:0] r_sub;
  logic [7:0]    r_slip_cnt;
  logic [15:0]   r_err_cnt;
  logic [GW-1:0] r_good;
  logic [BW-1:0] r_bad;
  logic [7:0]    r_settle;

  logic [WW-1:0] w_word;
  logic          w_wv;
  logic          w_match;
  logic          w_timeout;
  logic          w_sub_wrap;
  logic          w_slip;

  red_pitaya_daisy_rx_gearbox #(
    .DW (DW),
    .NS (NS)
  ) u_gearbox (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .slc_dat_i (slc_dat_i),
    .slip_i    (r_sslip),
    .word_o    (w_word),
    .wv_o      (w_wv)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_en_sync    <= '0;
      r_train_sync <= '0;
    end else begin
      r_en_sync    <= {r_en_sync[YS-2:0], cfg_en_i};
      r_train_sync <= {r_train_sync[YS-2:0], cfg_train_i};
    end
  end

  always_comb begin
    w_en       = r_en_sync[YS-1];
    w_train    = r_train_sync[YS-1];
    w_match    = (w_word == TRAIN_PAT);
    w_timeout  = (r_try == TW'(MAX_TRY-1));
    w_sub_wrap = (r_sub == SW'(DW-1));
    w_slip     = w_wv && w_train && !w_match &&
                 ((r_state == ST_HUNT) || (r_state == ST_CHECK));
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= ST_OFF;
      r_bitslip  <= 1'b0;
      r_sslip    <= 1'b0;
      r_locked   <= 1'b0;
      r_fail     <= 1'b0;
      r_try      <= '0;
      r_sub      <= '0;
      r_slip_cnt <= '0;
      r_err_cnt  <= '0;
      r_good     <= '0;
      r_bad      <= '0;
      r_settle   <= '0;
    end else begin
      r_bitslip <= 1'b0;
      r_sslip   <= 1'b0;
      if (!w_en) begin
        r_state    <= ST_OFF;
        r_locked   <= 1'b0;
        r_fail     <= 1'b0;
        r_try      <= '0;
        r_sub      <= '0;
        r_slip_cnt <= '0;
        r_err_cnt  <= '0;
        r_good     <= '0;
        r_bad      <= '0;
        r_settle   <= '0;
      end else begin
        unique case (r_state)
          ST_OFF: begin
            r_locked   <= 1'b0;
            r_try      <= '0;
            r_sub      <= '0;
            r_slip_cnt <= '0;
            r_err_cnt  <= '0;
            r_good     <= '0;
            r_bad      <= '0;
            r_settle   <= '0;
            if (w_train) begin
              r_fail  <= 1'b0;
              r_state <= ST_HUNT;
            end
          end
          ST_HUNT: begin
            if (!w_train) begin
              r_state <= ST_OFF;
            end else if (w_wv) begin
              if (w_match) begin
                r_good  <= GW'(1);
                r_state <= ST_CHECK;
              end else begin
                r_state <= w_timeout ? ST_FAIL : ST_SETTLE;
                r_fail  <= w_timeout;
              end
            end
          end
          ST_SETTLE: begin
            if (!w_train) begin
              r_state <= ST_OFF;
            end else if (r_settle == 8'(SETTLE-1)) begin
              r_state <= ST_HUNT;
            end else begin
              r_settle <= r_settle + 8'd1;
            end
          end
          ST_CHECK: begin
            if (!w_train) begin
              r_state <= ST_OFF;
            end else if (w_wv) begin
              if (w_match) begin
                r_good <= r_good + GW'(1);
                if (r_good == GW'(LOCK_N-1)) begin
                  r_state  <= ST_LOCKED;
                  r_locked <= 1'b1;
                end
              end else begin
                r_good  <= '0;
                r_state <= w_timeout ? ST_FAIL : ST_SETTLE;
                r_fail  <= w_timeout;
              end
            end
          end
          ST_LOCKED: begin
            if (w_train && w_wv) begin
              if (w_match) begin
                r_bad <= '0;
              end else begin
                if (r_err_cnt != '1) begin
                  r_err_cnt <= r_err_cnt + 16'd1;
                end
                if (r_bad == BW'(UNLOCK_N-1)) begin
                  r_state  <= ST_HUNT;
                  r_locked <= 1'b0;
                  r_try    <= '0;
                  r_sub    <= '0;
                  r_good   <= '0;
                  r_bad    <= '0;
                end else begin
                  r_bad <= r_bad + BW'(1);
                end
              end
            end
          end
          ST_FAIL: begin
            if (!w_train) begin
              r_state <= ST_OFF;
            end
          end
          default: r_state <= ST_OFF;
        endcase

        // Slip side effects shared by HUNT and CHECK mismatches; state choice is made in the case above.
        if (w_slip) begin
          r_bitslip <= 1'b1;
          r_sslip   <= w_sub_wrap;
          r_sub     <= w_sub_wrap ? '0 : r_sub + SW'(1);
          r_try     <= r_try + TW'(1);
          r_settle  <= '0;
          if (r_slip_cnt != '1) begin
            r_slip_cnt <= r_slip_cnt + 8'd1;
          end
        end
      end
    end
  end

  assign bitslip_o      = r_bitslip;
  assign par_dv_o       = w_wv && (r_state == ST_LOCKED) && !w_train;
  assign par_dat_o      = w_word;
  assign sts_locked_o   = r_locked;
  assign sts_fail_o     = r_fail;
  assign sts_err_cnt_o  = r_err_cnt;
  assign sts_slip_cnt_o = r_slip_cnt;

endmodule

// File: tb/tb_red_pitaya_daisy_rx_align.sv
// Directed bench for the daisy-chain receiver aligner with a bit-rotating deserialiser model.
module tb_red_pitaya_daisy_rx_align;

  logic        clk_i;
  logic        rstn_i;
  logic        cfg_en_i;
  logic        cfg_train_i;
  logic [3:0]  slc_dat_i;
  logic        bitslip_o;
  logic        par_dv_o;
  logic [15:0] par_dat_o;
  logic        sts_locked_o;
  logic        sts_fail_o;
  logic [15:0] sts_err_cnt_o;
  logic [7:0]  sts_slip_cnt_o;

  int unsigned n_cmp;
  int unsigned n_bad;
  int unsigned n_pulse;

  // stream model: pos is the bit index of the current slice LSB, bo the deserialiser bit rotation
  int  pos;
  int  bo;
  bit  junk;
  int  pay_lo, pay_hi;
  int  bad_lo, bad_hi;
  bit  bs_seen;

  red_pitaya_daisy_rx_align #(
    .DW        (4),
    .NS        (4),
    .TRAIN_PAT (16'h00FF),
    .SETTLE    (8),
    .LOCK_N    (4),
    .UNLOCK_N  (4),
    .MAX_TRY   (32)
  ) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .cfg_en_i       (cfg_en_i),
    .cfg_train_i    (cfg_train_i),
    .slc_dat_i      (slc_dat_i),
    .bitslip_o      (bitslip_o),
    .par_dv_o       (par_dv_o),
    .par_dat_o      (par_dat_o),
    .sts_locked_o   (sts_locked_o),
    .sts_fail_o     (sts_fail_o),
    .sts_err_cnt_o  (sts_err_cnt_o),
    .sts_slip_cnt_o (sts_slip_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] word_at(input int n);
    if (junk) return 16'hAAAA;
    if (n >= pay_lo && n < pay_hi) return 16'hA5C3 + 16'(n - pay_lo);
    if (n >= bad_lo && n < bad_hi) return 16'h0F0F;
    return 16'h00FF;
  endfunction

  function automatic logic [3:0] get_slice(input int p);
    logic [3:0]  s;
    logic [15:0] w;
    int          k;
    for (int i = 0; i < 4; i++) begin
      k    = p + i;
      w    = word_at(k / 16);
      s[i] = w[k % 16];
    end
    return s;
  endfunction

  initial begin
    forever begin
      @(negedge clk_i);
      bs_seen = bitslip_o;
      @(posedge clk_i);
      #1;
      pos = pos + 4;
      if (bs_seen) begin
        if (bo == 3) begin
          bo  = 0;
          pos = pos - 3;
        end else begin
          bo  = bo + 1;
          pos = pos + 1;
        end
      end
      slc_dat_i = get_slice(pos);
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (bitslip_o === 1'b1) n_pulse++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  task automatic do_reset(input int base, input bit jm);
    @(negedge clk_i);
    rstn_i      = 1'b0;
    cfg_en_i    = 1'b1;
    cfg_train_i = 1'b1;
    junk        = jm;
    pay_lo = 0; pay_hi = 0; bad_lo = 0; bad_hi = 0;
    repeat (3) @(negedge clk_i);
    n_pulse   = 0;
    pos       = base;
    bo        = 0;
    slc_dat_i = get_slice(pos);
    rstn_i    = 1'b1;
  endtask

  task automatic wait_locked(input string tag, input logic val, input int budget, output int cyc);
    cyc = 0;
    while (sts_locked_o !== val && cyc < budget) begin
      @(negedge clk_i);
      cyc++;
    end
    check_eq(tag, sts_locked_o, val);
  endtask

  int cyc;
  int dv_hits;

  initial begin
    n_cmp = 0; n_bad = 0; n_pulse = 0;
    rstn_i = 1'b0; cfg_en_i = 1'b0; cfg_train_i = 1'b0; slc_dat_i = '0;
    pos = 0; bo = 0; junk = 0; pay_lo = 0; pay_hi = 0; bad_lo = 0; bad_hi = 0;

    // reset state
    repeat (3) @(negedge clk_i);
    check_eq("rst_bitslip", bitslip_o, 1'b0);
    check_eq("rst_dv", par_dv_o, 1'b0);
    check_eq("rst_dat", par_dat_o, 16'h0000);
    check_eq("rst_locked", sts_locked_o, 1'b0);
    check_eq("rst_fail", sts_fail_o, 1'b0);
    check_eq("rst_err", sts_err_cnt_o, 16'h0000);
    check_eq("rst_slip", sts_slip_cnt_o, 8'h00);

    // 1: aligned stream
    do_reset(0, 1'b0);
    wait_locked("t1_lock", 1'b1, 60, cyc);
    check_eq("t1_lock_cycles", 32'(cyc), 32'd17);
    repeat (2) @(negedge clk_i);
    check_eq("t1_pulses", n_pulse, 32'd0);
    check_eq("t1_slip_cnt", sts_slip_cnt_o, 8'd0);
    check_eq("t1_fail", sts_fail_o, 1'b0);

    // 2: six bits off
    do_reset(10, 1'b0);
    wait_locked("t2_lock", 1'b1, 400, cyc);
    repeat (2) @(negedge clk_i);
    check_eq("t2_pulses", n_pulse, 32'd6);
    check_eq("t2_slip_cnt", sts_slip_cnt_o, 8'd6);

    // 3: pattern never present
    do_reset(0, 1'b1);
    cyc = 0;
    while (sts_fail_o !== 1'b1 && cyc < 1000) begin
      @(negedge clk_i);
      cyc++;
    end
    check_eq("t3_fail", sts_fail_o, 1'b1);
    repeat (2) @(negedge clk_i);
    check_eq("t3_pulses", n_pulse, 32'd32);
    check_eq("t3_slip_cnt", sts_slip_cnt_o, 8'd32);
    check_eq("t3_locked", sts_locked_o, 1'b0);
    repeat (100) @(negedge clk_i);
    check_eq("t3_no_more", n_pulse, 32'd32);
    cfg_train_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check_eq("t3_fail_hold", sts_fail_o, 1'b1);
    check_eq("t3_off_slip", sts_slip_cnt_o, 8'd0);
    cfg_train_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check_eq("t3_fail_clr", sts_fail_o, 1'b0);
    cyc = 0;
    while (bitslip_o !== 1'b1 && cyc < 40) begin
      @(negedge clk_i);
      cyc++;
    end
    check_eq("t3_rehunt", bitslip_o, 1'b1);
    check_eq("t3_rehunt_cnt", sts_slip_cnt_o, 8'd1);

    // 4: pass-through payload
    do_reset(0, 1'b0);
    wait_locked("t4_lock", 1'b1, 60, cyc);
    cfg_train_i = 1'b0;
    repeat (8) @(negedge clk_i);
    pay_lo = pos / 16 + 2;
    pay_hi = pay_lo + 8;
    cyc = 0;
    while (!(par_dv_o === 1'b1 && par_dat_o !== 16'h00FF) && cyc < 60) begin
      @(negedge clk_i);
      cyc++;
    end
    check_eq("t4_dv0", par_dv_o, 1'b1);
    check_eq("t4_dat0", par_dat_o, 16'hA5C3);
    for (int k = 1; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk_i);
        if (c < 3) begin
          check_eq("t4_dv_gap", par_dv_o, 1'b0);
        end else begin
          check_eq("t4_dv", par_dv_o, 1'b1);
          check_eq("t4_dat", par_dat_o, 16'hA5C3 + 16'(k));
        end
      end
    end
    check_eq("t4_err", sts_err_cnt_o, 16'd0);
    check_eq("t4_locked", sts_locked_o, 1'b1);

    // 5: errors while locked and training
    pay_hi = 0;
    repeat (8) @(negedge clk_i);
    cfg_train_i = 1'b1;
    repeat (8) @(negedge clk_i);
    bad_lo = pos / 16 + 2;
    bad_hi = bad_lo + 3;
    repeat (60) @(negedge clk_i);
    check_eq("t5_hold_locked", sts_locked_o, 1'b1);
    check_eq("t5_err3", sts_err_cnt_o, 16'd3);
    bad_lo = pos / 16 + 2;
    bad_hi = bad_lo + 4;
    wait_locked("t5_unlock", 1'b0, 60, cyc);
    check_eq("t5_err7", sts_err_cnt_o, 16'd7);
    wait_locked("t5_relock", 1'b1, 100, cyc);
    check_eq("t5_err_kept", sts_err_cnt_o, 16'd7);

    // 6a: async reset while settling
    do_reset(0, 1'b1);
    cyc = 0;
    while (bitslip_o !== 1'b1 && cyc < 60) begin
      @(negedge clk_i);
      cyc++;
    end
    check_eq("t6_pre_slip", sts_slip_cnt_o, 8'd1);
    rstn_i = 1'b0;
    #1;
    check_eq("t6_bitslip", bitslip_o, 1'b0);
    check_eq("t6_dv", par_dv_o, 1'b0);
    check_eq("t6_dat", par_dat_o, 16'h0000);
    check_eq("t6_locked", sts_locked_o, 1'b0);
    check_eq("t6_fail", sts_fail_o, 1'b0);
    check_eq("t6_err", sts_err_cnt_o, 16'h0000);
    check_eq("t6_slip", sts_slip_cnt_o, 8'h00);

    // 6b: enable dropped while locked
    do_reset(0, 1'b0);
    wait_locked("t6_lock", 1'b1, 60, cyc);
    cfg_train_i = 1'b0;
    repeat (12) @(negedge clk_i);
    cfg_en_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_eq("t6_en_still", sts_locked_o, 1'b1);
    @(negedge clk_i);
    check_eq("t6_en_locked", sts_locked_o, 1'b0);
    dv_hits = 0;
    for (int c = 0; c < 8; c++) begin
      if (par_dv_o === 1'b1) dv_hits++;
      @(negedge clk_i);
    end
    check_eq("t6_en_dv", 32'(dv_hits), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
